// File: rtl/apresentador_sequencia_if.sv
// Bus between the sequence presenter, its game controller, the sequence RAM
// and the player LEDs.
//   iniciar      start request             rodada    last address to show
//   mem_dado     RAM read data             mem_endereco  RAM read address
//   leds         value shown to player     ocupado   playback in progress
//   pronto       one-cycle done pulse      db_estado debug FSM state
// slave: the presenter. master: controller/RAM side.
interface apresentador_sequencia_if;
  logic       iniciar;
  logic [3:0] rodada;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  modport slave (
    input  iniciar, rodada, mem_dado,
    output mem_endereco, leds, ocupado, pronto, db_estado
  );

  modport master (
    output iniciar, rodada, mem_dado,
    input  mem_endereco, leds, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/apresentador_sequencia.sv
// Plays the stored game sequence (addresses 0..rodada) back on the LEDs:
// each value lit for LED_ON_CYCLES, then dark for GAP_CYCLES, then a
// one-cycle pronto pulse.
//   clock  system clock (rising edge)
//   reset  asynchronous, active-high
//   bus    apresentador_sequencia_if.slave (start/round in, RAM port,
//          LEDs, ocupado/pronto status, debug state)
module apresentador_sequencia #(
  parameter int unsigned LED_ON_CYCLES = 2000,
  parameter int unsigned GAP_CYCLES    = 500
) (
  input  logic                     clock,
  input  logic                     reset,
  apresentador_sequencia_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (LED_ON_CYCLES > GAP_CYCLES) ? LED_ON_CYCLES : GAP_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(LED_ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENDERECA = 3'd1,
    ACENDE   = 3'd2,
    APAGA    = 3'd3,
    FIM      = 3'd4
  } estado_t;

  estado_t       estado_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    rodada_q;
  logic [3:0]    endereco_q;
  logic [3:0]    leds_q;
  logic          ocupado_q;
  logic          pronto_q;

  // Playback FSM; all outputs come straight from registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      timer_q    <= '0;
      rodada_q   <= '0;
      endereco_q <= '0;
      leds_q     <= '0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (bus.iniciar) begin
            rodada_q   <= bus.rodada;
            endereco_q <= '0;
            ocupado_q  <= 1'b1;
            estado_q   <= ENDERECA;
          end
        end
        // Address was presented last edge; RAM data is valid now.
        ENDERECA: begin
          leds_q   <= bus.mem_dado;
          timer_q  <= '0;
          estado_q <= ACENDE;
        end
        ACENDE: begin
          if (timer_q == ON_LAST) begin
            leds_q   <= '0;
            timer_q  <= '0;
            estado_q <= APAGA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        APAGA: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            if (endereco_q == rodada_q) begin
              pronto_q <= 1'b1;
              estado_q <= FIM;
            end else begin
              endereco_q <= endereco_q + 4'd1;
              estado_q   <= ENDERECA;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        // pronto is high for this single cycle; ocupado drops on exit.
        FIM: begin
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign bus.mem_endereco = endereco_q;
  assign bus.leds         = leds_q;
  assign bus.ocupado      = ocupado_q;
  assign bus.pronto       = pronto_q;
  assign bus.db_estado    = estado_q;

endmodule

// File: tb/tb_apresentador_sequencia.sv
module tb_apresentador_sequencia;

  localparam int unsigned ON  = 4;
  localparam int unsigned GAP = 2;
  localparam int unsigned PER = 1 + ON + GAP;

  typedef struct {
    int unsigned val;
    int unsigned start;
    int unsigned len;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ram [16];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  ev_t q_led[$];
  ev_t q_pr[$];
  ev_t q_oc[$];

  apresentador_sequencia_if bus ();

  apresentador_sequencia #(
    .LED_ON_CYCLES (ON),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data for the registered address is ready by the next edge.
  assign bus.mem_dado = ram[bus.mem_endereco];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Expected LED windows, pronto pulse and ocupado span for one playback.
  task automatic expect_seq(input int unsigned s, input int unsigned r);
    ev_t e;
    for (int unsigned k = 0; k <= r; k++) begin
      if (ram[k] != 4'd0) begin
        e.val = 32'(ram[k]); e.start = s + 2 + PER * k; e.len = ON;
        q_led.push_back(e);
      end
    end
    e.val = r; e.start = s + (r + 1) * PER + 1; e.len = 1;
    q_pr.push_back(e);
    e.val = 1; e.start = s + 1; e.len = (r + 1) * PER + 1;
    q_oc.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int unsigned v, input int unsigned st,
                        input int unsigned ln);
    ev_t   e;
    bit    have;
    string nm;
    have = 1'b0;
    n_tests++;
    case (kind)
      0: begin nm = "leds";    if (q_led.size() > 0) begin e = q_led.pop_front(); have = 1'b1; end end
      1: begin nm = "pronto";  if (q_pr.size()  > 0) begin e = q_pr.pop_front();  have = 1'b1; end end
      default: begin nm = "ocupado"; if (q_oc.size() > 0) begin e = q_oc.pop_front(); have = 1'b1; end end
    endcase
    if (!have) begin
      n_fail++;
      $display("FAIL %s unexpected: got val=%0d start=%0d len=%0d, expected none", nm, v, st, ln);
    end else if (e.val != v || e.start != st || e.len != ln) begin
      n_fail++;
      $display("FAIL %s: got val=%0d start=%0d len=%0d, expected val=%0d start=%0d len=%0d",
               nm, v, st, ln, e.val, e.start, e.len);
    end
  endtask

  // Monitor: turns output activity into runs and checks each against the scoreboard.
  initial begin : monitor
    logic [3:0]  led_prev;
    int unsigned led_st, pr_st, pr_val, oc_st;
    logic        pr_prev, oc_prev;
    led_prev = 4'd0; pr_prev = 1'b0; oc_prev = 1'b0;
    led_st = 0; pr_st = 0; pr_val = 0; oc_st = 0;
    forever begin
      @(negedge clk);
      if (bus.leds !== led_prev) begin
        if (led_prev != 4'd0) sb_pop(0, 32'(led_prev), led_st, cyc - led_st);
        if (bus.leds !== 4'd0) led_st = cyc;
        led_prev = (bus.leds === 4'bxxxx) ? 4'd0 : bus.leds;
      end
      if (bus.pronto === 1'b1 && !pr_prev) begin
        pr_st = cyc; pr_val = 32'(bus.mem_endereco);
      end
      if (bus.pronto !== 1'b1 && pr_prev) sb_pop(1, pr_val, pr_st, cyc - pr_st);
      pr_prev = (bus.pronto === 1'b1);
      if (bus.ocupado === 1'b1 && !oc_prev) oc_st = cyc;
      if (bus.ocupado !== 1'b1 && oc_prev) sb_pop(2, 1, oc_st, cyc - oc_st);
      oc_prev = (bus.ocupado === 1'b1);
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [3:0] r, output int unsigned s);
    step();
    bus.rodada  = r;
    bus.iniciar = 1'b1;
    s = cyc;
    expect_seq(s, 32'(r));
    step();
    bus.iniciar = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((q_led.size() + q_pr.size() + q_oc.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk({nm, " pending events"}, 32'(q_led.size() + q_pr.size() + q_oc.size()), 32'd0);
    q_led.delete(); q_pr.delete(); q_oc.delete();
    repeat (3) step();
  endtask

  initial begin : stim
    int unsigned s;
    ev_t e;
    for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));
    rst = 1'b1;
    bus.iniciar = 1'b0;
    bus.rodada  = 4'd0;
    repeat (3) step();
    chk("reset leds", 32'(bus.leds), 32'd0);
    chk("reset ocupado", 32'(bus.ocupado), 32'd0);
    chk("reset pronto", 32'(bus.pronto), 32'd0);
    chk("reset db_estado", 32'(bus.db_estado), 32'd0);
    chk("reset mem_endereco", 32'(bus.mem_endereco), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // single element
    start(4'd0, s);
    wait_done("single", 40);

    // three elements
    start(4'd2, s);
    wait_done("three", 60);
    chk("three final addr", 32'(bus.mem_endereco), 32'd2);

    // stored zero: dark window, pronto timing unchanged
    ram[0] = 4'd0;
    start(4'd0, s);
    wait_done("zero", 40);
    ram[0] = 4'd1;

    // iniciar/rodada changes during playback are ignored; restart on cycle 16
    start(4'd1, s);
    while (cyc < s + 5) step();
    bus.iniciar = 1'b1; bus.rodada = 4'd5;
    step();
    bus.iniciar = 1'b0;
    while (cyc < s + 16) step();
    bus.iniciar = 1'b1; bus.rodada = 4'd0;
    expect_seq(s + 16, 0);
    step();
    bus.iniciar = 1'b0;
    wait_done("restart blocked", 80);

    // iniciar held high: back-to-back playbacks one idle cycle apart
    step();
    bus.rodada = 4'd0; bus.iniciar = 1'b1;
    s = cyc;
    expect_seq(s, 0);
    expect_seq(s + PER + 2, 0);
    while (cyc < s + PER + 3) step();
    bus.iniciar = 1'b0;
    wait_done("held start", 60);

    // full sequence
    start(4'd15, s);
    wait_done("full", 200);
    chk("full final addr", 32'(bus.mem_endereco), 32'd15);

    // reset during element 1 lit window: truncated runs, no pronto
    start(4'd1, s);
    q_pr.delete(); q_oc.delete(); q_led.delete();
    e.val = 1; e.start = s + 2;  e.len = ON; q_led.push_back(e);
    e.val = 2; e.start = s + 9;  e.len = 2;  q_led.push_back(e);
    e.val = 1; e.start = s + 1;  e.len = 10; q_oc.push_back(e);
    while (cyc < s + 11) step();
    rst = 1'b1;
    #1;
    chk("async rst leds", 32'(bus.leds), 32'd0);
    chk("async rst ocupado", 32'(bus.ocupado), 32'd0);
    chk("async rst db_estado", 32'(bus.db_estado), 32'd0);
    chk("async rst mem_endereco", 32'(bus.mem_endereco), 32'd0);
    step();
    rst = 1'b0;
    wait_done("reset mid", 40);
    repeat (20) step();

    // reset and iniciar together: reset wins
    rst = 1'b1; bus.iniciar = 1'b1;
    step();
    chk("rst+iniciar db_estado", 32'(bus.db_estado), 32'd0);
    chk("rst+iniciar ocupado", 32'(bus.ocupado), 32'd0);
    rst = 1'b0; bus.iniciar = 1'b0;
    repeat (2) step();

    // fresh start after reset runs from address 0
    start(4'd1, s);
    wait_done("after reset", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apresentador_sequencia.md
# apresentador_sequencia

Plays the stored game sequence back to the player. On a start pulse it reads RAM addresses 0 through the current round index, in order. It shows each stored 4-bit value on the LEDs for a fixed time, followed by a dark gap. It then signals completion to the game's control unit. It is the output side of the game: the existing datapath takes button presses and compares them against memory, and this block presents that memory to the player before each round's input phase.

## Interface
Parameters:
- `LED_ON_CYCLES`, default 2000, clock cycles each value stays lit (≥1)
- `GAP_CYCLES`, default 500, clock cycles LEDs stay dark after each value (≥1)

Ports:
- `clock` in 1: single system clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-high; forces all state to reset values immediately
- `iniciar` in 1: start request; sampled only in OCIOSO
- `rodada` in 4: index of the last address to present (0–15); captured when start is accepted
- `mem_dado` in 4: read data from the synchronous 16x4 RAM; valid one cycle after `mem_endereco`
- `mem_endereco` out 4: RAM read address
- `leds` out 4: value driven to the player LEDs
- `ocupado` out 1: high from start acceptance until `pronto` has been asserted
- `pronto` out 1: one-cycle pulse when the sequence has been fully shown
- `db_estado` out 3: current FSM state encoding, for debug

## Operation
- Reset values: state OCIOSO; `mem_endereco`=0, `leds`=0, `ocupado`=0, `pronto`=0, internal timer=0, captured round register=0.
- State encodings: OCIOSO=0, ENDERECA=1, ACENDE=2, APAGA=3, FIM=4.
- OCIOSO
  - If `iniciar`=1: capture `rodada` into `rodada_reg`, set `mem_endereco`=0, go to ENDERECA.
  - Otherwise stay.
- ENDERECA: one cycle covering the RAM read latency. At the edge ending this state:
  - register `mem_dado` into `leds`;
  - clear the timer;
  - go to ACENDE.
- ACENDE
  - `leds` holds the registered value.
  - The timer counts up.
  - On the cycle the timer equals `LED_ON_CYCLES`-1: clear `leds` and the timer, go to APAGA.
- APAGA
  - `leds`=0 and the timer counts up.
  - On the cycle the timer equals `GAP_CYCLES`-1:
    - if `mem_endereco`==`rodada_reg`, go to FIM;
    - otherwise increment `mem_endereco` and go to ENDERECA.
- FIM: `pronto`=1 for exactly this one cycle, then go to OCIOSO. `mem_endereco` holds its last value until the next start.
- `ocupado`=1 in ENDERECA, ACENDE, APAGA and FIM; 0 in OCIOSO.
- Stored values are displayed as-is; nothing is one-hot decoded. A stored 0 gives a dark ACENDE interval that still lasts the full `LED_ON_CYCLES`.
- Timer width: ceil(log2(max(LED_ON_CYCLES, GAP_CYCLES))) bits. The timer never wraps.

## Timing
- Cycle 0 is the edge at which `iniciar` is sampled high in OCIOSO.
- Each element k (0..`rodada_reg`) occupies exactly 1 + `LED_ON_CYCLES` + `GAP_CYCLES` cycles.
  - `leds` shows element k for exactly `LED_ON_CYCLES` consecutive cycles.
  - This window starts 2 + k·(1+ON+GAP) cycles after cycle 0.
- `pronto` rises (`rodada_reg`+1)·(1+ON+GAP) + 1 cycles after cycle 0 and lasts one cycle.
- The earliest new start is accepted on the cycle after `pronto`, once the FSM is back in OCIOSO.
- Boundary conditions:
  - `iniciar` held high continuously: the sequence restarts after each return to OCIOSO.
  - `iniciar` while `ocupado`=1: ignored; no restart, no effect.
  - `rodada` changes during playback: ignored, because `rodada_reg` governs.
  - `rodada`=15: addresses 0–15 are presented and the address never wraps past 15.
  - `rodada`=0: exactly one element is shown.
  - `reset` asserted mid-playback: all outputs go to reset values asynchronously and the FSM goes to OCIOSO. `pronto` is not emitted.
  - `reset` and `iniciar` high together: reset wins.

## Test plan
All scenarios use `LED_ON_CYCLES`=4, `GAP_CYCLES`=2 and a RAM model preloaded with 1,2,4,8,… with one-cycle read latency.
- Single element: `rodada`=0, pulse `iniciar` → `leds`=1 for 4 cycles starting cycle 2, then 0; `pronto` pulses at cycle 8; `ocupado` high cycles 1–8.
- Three elements: `rodada`=2 → `leds` shows 1, 2, 4, each for 4 cycles, separated by 3 dark cycles (gap + address); `pronto` at cycle 22; `mem_endereco` ends at 2.
- Full sequence: `rodada`=15 → 16 lit windows in order; `pronto` at cycle 16·7+1=113; `mem_endereco` never exceeds 15.
- Restart blocked: re-pulse `iniciar` and change `rodada` to 5 mid-playback of `rodada`=1 → playback unchanged; `pronto` at cycle 15; a new start on cycle 16 is accepted.
- Reset mid-operation: assert `reset` during ACENDE of element 1 → `leds`=0, `ocupado`=0, `db_estado`=0 immediately; no `pronto`; a subsequent start runs from address 0.
- Zero data: RAM address 0 holds 0, `rodada`=0 → `leds` stays 0 throughout; `pronto` still at cycle 8.
